ttl_input_capture: RTL and testbench
====================================

Name: ttl_input_capture

Overview:
- Receive-side counterpart of the TTL output controller: samples 32 TTL inputs and timestamps every enabled edge.
- The inputs arrive already single-ended; the LVDS input buffers sit in the top-level wrapper.
- Events are packed into 128-bit words matching the AXI data width, buffered in a FIFO and handed out on a valid/ready stream.
- The stream is consumed by the AXI read path, so software can read edge times.

Parameters:
- NUM_CH, 32, number of TTL input channels (fixed at 32 in this revision).
- TS_WIDTH, 64, timestamp counter width.
- FIFO_DEPTH, 256, event FIFO depth in entries; power of 2, ≥4.
- FIFO_AW, 8, log2(FIFO_DEPTH).
- DROP_WIDTH, 16, width of the dropped-event counter.

Ports:
- s_axi_aclk  in  1  single clock for the whole block.
- s_axi_areset  in  1  synchronous active-high reset.
- ttl_in  in  32  asynchronous TTL levels from the input buffers.
- capture_enable  in  1  enables FIFO pushes.
- rise_mask  in  32  per-channel rising-edge capture enable.
- fall_mask  in  32  per-channel falling-edge capture enable.
- clear  in  1  one-cycle pulse: flush FIFO, clear overflow and drop_count.
- ts_reset  in  1  one-cycle pulse: timestamp counter to 0.
- event_data  out  128  [127:64] timestamp, [63:32] fall bits, [31:0] rise bits.
- event_valid  out  1  FIFO head valid.
- event_ready  in  1  consumer accepts head.
- fifo_count  out  FIFO_AW+1  entries currently stored.
- overflow  out  1  sticky: at least one event dropped.
- drop_count  out  DROP_WIDTH  dropped events; saturates at all-ones.
- ttl_level  out  32  synchronized current input levels.

Behaviour:
- Reset (s_axi_areset high at a clock edge):
  - All synchronizer stages, the previous-level register, timestamp, FIFO pointers, overflow and drop_count go to 0.
  - Outputs after reset: event_valid=0, event_data=0, fifo_count=0, ttl_level=0.
  - Reset mid-operation discards FIFO contents immediately.
- Synchronizer:
  - 2-FF synchronizer per channel (sync1, sync2); prev <= sync2 every cycle.
  - prev updates regardless of capture_enable, so enabling never produces stale edges.
  - ttl_level = sync2.
- Edge detection (combinational on sync2/prev):
  - rise = sync2 & ~prev & rise_mask.
  - fall = ~sync2 & prev & fall_mask.
  - event = capture_enable & |(rise|fall).
- Timestamp:
  - Free-running; reads 0 in the first cycle after reset deasserts; +1 per cycle; wraps at 2^TS_WIDTH-1 → 0 silently.
  - ts_reset loads 0 at the next edge.
  - Entry timestamp = counter value in the cycle the edge is seen on sync2 vs prev.
- Latency:
  - An ttl_in change meeting setup before edge N is pushed at edge N+2.
  - With the FIFO empty, event_valid goes high after edge N+3; the FIFO has a registered output.
  - Multiple channels changing in the same synchronized cycle produce ONE entry with several bits set.
- FIFO:
  - Show-ahead; event_data is stable while event_valid=1 and event_ready=0.
  - Pop on event_valid & event_ready.
  - Push when event is high and the FIFO is not full, OR the FIFO is full with a pop in the same cycle; in that case the push is accepted and count is unchanged.
  - Push when full without a pop: entry dropped, overflow<=1, drop_count+1 (saturating).
  - Simultaneous push and pop on an empty FIFO: no pop occurs (valid=0); push proceeds.
- Priority: s_axi_areset > clear > normal operation.
  - clear empties the FIFO, so event_valid=0 at the next cycle.
  - An event coincident with clear is discarded and is not counted as a drop.
- Control state machine: DISABLED / RUNNING / DRAINING.
  - DISABLED → RUNNING: capture_enable=1.
  - RUNNING → DRAINING: capture_enable=0 while fifo_count>0.
  - RUNNING → DISABLED: capture_enable=0 while fifo_count=0.
  - DRAINING → DISABLED: fifo_count=0.
  - DRAINING → RUNNING: capture_enable=1.
  - Pushes occur only in RUNNING; pops are allowed in every state.
  - clear forces DISABLED if capture_enable=0, otherwise RUNNING.

Decomposition:
- Package ttl_capture_pkg:
  - entry field offsets (TS_LSB=64, FALL_LSB=32, RISE_LSB=0), ENTRY_WIDTH=128;
  - typedef capture_state_t {DISABLED, RUNNING, DRAINING};
  - typedef ttl_event_t packed struct {ts, fall, rise}.
- One sub-module, ttl_event_fifo: synchronous show-ahead FIFO with push, pop, clear, count, full and empty, on a single clock.
- Synchronizer, edge detect, timestamp and state machine stay in the top module.

Test Plan:
- Reset, then idle 20 cycles with ttl_in constant → event_valid=0, fifo_count=0, ttl_level equals ttl_in after 2 cycles.
- rise_mask=all ones, enable; ttl_in[3] 0→1, then ttl_in[3] 1→0 ten cycles later with fall_mask[3]=1 → two entries:
  - rise=0x8 then fall=0x8;
  - timestamps differ by exactly 10;
  - first event_valid appears 3 cycles after the input edge.
- Bits 0, 7 and 31 rise in the same cycle with rise_mask=0x80000081 → one entry, rise=0x80000081, fall=0.
- With event_ready=0, generate 260 edges (FIFO_DEPTH=256) → fifo_count=256, overflow=1, drop_count=4. Pop one entry while pushing on the same cycle → count stays 256 and drop_count stays 4.
- Fill 5 entries, pulse clear coincident with a new edge → fifo_count=0, overflow=0, drop_count=0, event_valid=0 next cycle, no entry for the coincident edge.
- Preload the timestamp near wrap by forcing TS_WIDTH=8 in the bench; event at count 255 then the next cycle → timestamps 255 and 0.
- Deassert capture_enable with 3 entries stored → state goes to DRAINING, the 3 entries are still poppable, and new edges are not stored.

Source files
------------

// File: rtl/ttl_capture_pkg.sv
// Shared types and entry layout for the TTL input capture block.
package ttl_capture_pkg;

  localparam int unsigned ENTRY_WIDTH = 128;
  localparam int unsigned TS_LSB      = 64;
  localparam int unsigned FALL_LSB    = 32;
  localparam int unsigned RISE_LSB    = 0;

  typedef enum logic [1:0] {
    StDisabled,
    StRunning,
    StDraining
  } capture_state_t;

  typedef struct packed {
    logic [63:0] ts;
    logic [31:0] fall;
    logic [31:0] rise;
  } ttl_event_t;

endpackage

// File: rtl/ttl_event_fifo.sv
// Show-ahead FIFO with a registered head: a pushed entry becomes visible on valid_o
// one cycle after the push, and count_o includes the entry held in the head register.
module ttl_event_fifo #(
  parameter int unsigned Width = 128,
  parameter int unsigned Depth = 256,
  parameter int unsigned Aw    = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  output logic [Aw:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned Cw = Aw + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Aw-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Aw:0]      mem_cnt_q, mem_cnt_d, count_q, count_d;
  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;
  logic             do_push, do_pop, load;

  assign full_o  = (count_q == Cw'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_comb begin
    do_pop    = pop_i & valid_q;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push   = push_i & (~full_o | do_pop);
    load      = (mem_cnt_q != '0) & (~valid_q | do_pop);
    wr_ptr_d  = do_push ? wr_ptr_q + Aw'(1) : wr_ptr_q;
    rd_ptr_d  = load ? rd_ptr_q + Aw'(1) : rd_ptr_q;
    mem_cnt_d = mem_cnt_q + Cw'(do_push) - Cw'(load);
    count_d   = count_q + Cw'(do_push) - Cw'(do_pop);
    valid_d   = load | (valid_q & ~do_pop);
    data_d    = load ? mem_q[rd_ptr_q] : data_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_cnt_q <= mem_cnt_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/ttl_input_capture.sv
// Synchronises 32 TTL inputs, timestamps enabled edges and queues them as 128-bit
// entries for the AXI read path.
module ttl_input_capture
  import ttl_capture_pkg::*;
#(
  parameter int unsigned NUM_CH     = 32,
  parameter int unsigned TS_WIDTH   = 64,
  parameter int unsigned FIFO_DEPTH = 256,
  parameter int unsigned FIFO_AW    = 8,
  parameter int unsigned DROP_WIDTH = 16
) (
  input  logic                   s_axi_aclk,
  input  logic                   s_axi_areset,
  input  logic [NUM_CH-1:0]      ttl_in,
  input  logic                   capture_enable,
  input  logic [NUM_CH-1:0]      rise_mask,
  input  logic [NUM_CH-1:0]      fall_mask,
  input  logic                   clear,
  input  logic                   ts_reset,
  output logic [ENTRY_WIDTH-1:0] event_data,
  output logic                   event_valid,
  input  logic                   event_ready,
  output logic [FIFO_AW:0]       fifo_count,
  output logic                   overflow,
  output logic [DROP_WIDTH-1:0]  drop_count,
  output logic [NUM_CH-1:0]      ttl_level
);

  logic [NUM_CH-1:0]     sync1_q, sync2_q, prev_q, rise, fall;
  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  capture_state_t        state_q, state_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_WIDTH-1:0] drop_q, drop_d;
  logic                  evt, push_req, drop, fifo_full, fifo_empty;
  ttl_event_t            entry;

  assign ttl_level  = sync2_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

  always_comb begin
    rise     = sync2_q & ~prev_q & rise_mask;
    fall     = ~sync2_q & prev_q & fall_mask;
    evt      = capture_enable & (|(rise | fall));
    // A clear in the same cycle swallows the event without counting it as a drop.
    push_req = evt & (state_q == StRunning) & ~clear;
    drop     = push_req & fifo_full & ~(event_valid & event_ready);
    entry.ts   = 64'(ts_q);
    entry.fall = fall;
    entry.rise = rise;
    ts_d       = ts_reset ? '0 : ts_q + TS_WIDTH'(1);
  end

  always_comb begin
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (clear) begin
      overflow_d = 1'b0;
      drop_d     = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + DROP_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = capture_enable ? StRunning : StDisabled;
    end else begin
      case (state_q)
        StDisabled: if (capture_enable) state_d = StRunning;
        StRunning:  if (!capture_enable) state_d = fifo_empty ? StDisabled : StDraining;
        StDraining: begin
          if (capture_enable)  state_d = StRunning;
          else if (fifo_empty) state_d = StDisabled;
        end
        default:    state_d = StDisabled;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      ts_q       <= '0;
      state_q    <= StDisabled;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      sync1_q    <= ttl_in;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      ts_q       <= ts_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  ttl_event_fifo #(
    .Width (ENTRY_WIDTH),
    .Depth (FIFO_DEPTH),
    .Aw    (FIFO_AW)
  ) u_fifo (
    .clk_i   (s_axi_aclk),
    .rst_i   (s_axi_areset),
    .clear_i (clear),
    .push_i  (push_req),
    .data_i  (entry),
    .pop_i   (event_ready),
    .data_o  (event_data),
    .valid_o (event_valid),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_ttl_input_capture.sv
// Scoreboard bench for ttl_input_capture, built with an 8-bit timestamp to reach wrap quickly.
module tb_ttl_input_capture;
  import ttl_capture_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  ttl_in, rise_mask, fall_mask, ttl_level;
  logic         capture_enable, clear, ts_reset, event_ready, event_valid, overflow;
  logic [127:0] event_data, last_data;
  logic [8:0]   fifo_count;
  logic [15:0]  drop_count;
  logic [7:0]   ts_m;
  logic [127:0] sb[$];
  logic [7:0]   got_ts[$];
  int           n_checks = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  ttl_input_capture #(
    .NUM_CH     (32),
    .TS_WIDTH   (8),
    .FIFO_DEPTH (256),
    .FIFO_AW    (8),
    .DROP_WIDTH (16)
  ) dut (
    .s_axi_aclk     (clk),
    .s_axi_areset   (rst),
    .ttl_in         (ttl_in),
    .capture_enable (capture_enable),
    .rise_mask      (rise_mask),
    .fall_mask      (fall_mask),
    .clear          (clear),
    .ts_reset       (ts_reset),
    .event_data     (event_data),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .drop_count     (drop_count),
    .ttl_level      (ttl_level)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference timestamp: value the counter holds during the current cycle.
  always @(posedge clk) begin
    if (rst || ts_reset) ts_m <= 8'd0;
    else                 ts_m <= ts_m + 8'd1;
  end

  always @(negedge clk) begin
    logic [127:0] exp;
    if (!rst && event_valid && event_ready) begin
      exp = (sb.size() > 0) ? sb.pop_front() : '1;
      check("sb_data", event_data, exp);
      got_ts.push_back(event_data[71:64]);
      last_data = event_data;
    end
  end

  // Change ttl_in just after a clock edge; the edge is seen on sync2 two cycles later.
  task automatic drive_ttl(input logic [31:0] nv, input bit store);
    logic [31:0] r, f;
    @(posedge clk); #1;
    r = nv & ~ttl_in & rise_mask;
    f = ~nv & ttl_in & fall_mask;
    if (store && ((r | f) != 32'd0)) sb.push_back({56'd0, 8'(ts_m + 8'd2), f, r});
    ttl_in = nv;
  endtask

  task automatic wait_count_zero(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (fifo_count == 9'd0) return;
    end
    check("drain_timeout", 128'(fifo_count), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    rst = 1'b1; ttl_in = 32'h5A5A_0A50; rise_mask = '0; fall_mask = '0;
    capture_enable = 1'b0; clear = 1'b0; ts_reset = 1'b0; event_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 128'(event_valid), 128'(0));
    check("rst_data", event_data, 128'(0));
    check("rst_count", 128'(fifo_count), 128'(0));
    check("rst_level", 128'(ttl_level), 128'(0));
    check("rst_ovf", 128'(overflow), 128'(0));
    check("rst_drop", 128'(drop_count), 128'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("level_1cyc", 128'(ttl_level), 128'(0));
    @(posedge clk); @(negedge clk);
    check("level_2cyc", 128'(ttl_level), 128'(ttl_in));
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("idle_valid", 128'(event_valid), 128'(0));
    check("idle_count", 128'(fifo_count), 128'(0));

    // Single-channel rise then fall, ten cycles apart.
    @(posedge clk); #1;
    rise_mask = '1; fall_mask = 32'h8; capture_enable = 1'b1;
    repeat (3) @(posedge clk);
    got_ts.delete();
    drive_ttl(ttl_in | 32'h8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("lat_valid_low", 128'(event_valid), 128'(0));
    end
    @(posedge clk); @(negedge clk);
    check("lat_valid_high", 128'(event_valid), 128'(1));
    @(posedge clk); #1 event_ready = 1'b1;
    repeat (4) @(posedge clk);
    drive_ttl(ttl_in & ~32'h8, 1'b1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("two_entries", 128'(got_ts.size()), 128'(2));
    d = (got_ts.size() == 2) ? got_ts[1] - got_ts[0] : 8'd0;
    check("ts_delta", 128'(d), 128'(10));
    check("fall_entry", last_data[63:0], {32'h8, 32'h0});

    // Several channels in one cycle, one of them masked.
    @(posedge clk); #1 rise_mask = 32'h8000_0081;
    drive_ttl(ttl_in | 32'h8000_0083, 1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("multi_rise", 128'(last_data[31:0]), 128'(32'h8000_0081));
    check("multi_fall", 128'(last_data[63:32]), 128'(0));
    check("multi_sb_empty", 128'(sb.size()), 128'(0));

    // Overflow: 260 entries into a 256-deep FIFO.
    @(posedge clk); #1;
    rise_mask = '1; fall_mask = '1; event_ready = 1'b0;
    for (int i = 0; i < 260; i++) drive_ttl(ttl_in ^ 32'h1, i < 256);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("full_count", 128'(fifo_count), 128'(256));
    check("full_ovf", 128'(overflow), 128'(1));
    check("full_drop", 128'(drop_count), 128'(4));
    drive_ttl(ttl_in ^ 32'h1, 1'b1);
    repeat (2) @(posedge clk);
    #1 event_ready = 1'b1;
    @(posedge clk); #1 event_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pushpop_count", 128'(fifo_count), 128'(256));
    check("pushpop_drop", 128'(drop_count), 128'(4));
    @(posedge clk); #1 event_ready = 1'b1;
    wait_count_zero(600);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("drain_sb_empty", 128'(sb.size()), 128'(0));
    check("drain_valid", 128'(event_valid), 128'(0));

    // Clear coincident with a new edge.
    @(posedge clk); #1 event_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive_ttl(ttl_in ^ 32'h1, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre_clear_count", 128'(fifo_count), 128'(5));
    drive_ttl(ttl_in ^ 32'h1, 1'b0);
    repeat (2) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    sb.delete();
    @(negedge clk);
    check("clr_count", 128'(fifo_count), 128'(0));
    check("clr_valid", 128'(event_valid), 128'(0));
    check("clr_ovf", 128'(overflow), 128'(0));
    check("clr_drop", 128'(drop_count), 128'(0));
    check("clr_state", 128'(dut.state_q), 128'(StRunning));
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("clr_no_entry", 128'(fifo_count), 128'(0));

    // Timestamp wrap across two consecutive events.
    @(posedge clk); #1 event_ready = 1'b1; ts_reset = 1'b1;
    @(posedge clk); #1 ts_reset = 1'b0;
    for (int g = 0; g < 600 && ts_m != 8'd252; g++) begin
      @(posedge clk); #1;
    end
    got_ts.delete();
    drive_ttl(ttl_in ^ 32'h10, 1'b1);
    drive_ttl(ttl_in ^ 32'h20, 1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("wrap_n", 128'(got_ts.size()), 128'(2));
    if (got_ts.size() == 2) begin
      check("wrap_ts0", 128'(got_ts[0]), 128'(255));
      check("wrap_ts1", 128'(got_ts[1]), 128'(0));
    end

    // Disable with entries pending.
    @(posedge clk); #1 event_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_ttl(ttl_in ^ 32'h1, 1'b1);
    repeat (4) @(posedge clk);
    #1 capture_enable = 1'b0;
    @(posedge clk); @(negedge clk);
    check("drain_state", 128'(dut.state_q), 128'(StDraining));
    check("drain_count", 128'(fifo_count), 128'(3));
    drive_ttl(ttl_in ^ 32'h40, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("drain_no_push", 128'(fifo_count), 128'(3));
    @(posedge clk); #1 event_ready = 1'b1;
    wait_count_zero(50);
    @(posedge clk); @(negedge clk);
    check("disabled_state", 128'(dut.state_q), 128'(StDisabled));
    check("final_sb_empty", 128'(sb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
